maze_move_ctrl: RTL and testbench
=================================

Name: maze_move_ctrl

Overview:
- Per-frame player-motion sequencer for the maze game.
- On each frame tick it takes one requested direction and steps the player bounding box one pixel at a time, up to STEP pixels.
- Before each pixel it waits for the wall-collision arrays (deny_up/down/left/right) to settle, then checks the matching deny flag and the screen edge.
- It owns the player box registers (top/bottom/left/right) that feed the collision checkers and the sprite renderer.

Parameters:
- PLAYER_W, 16, box width in pixels.
- PLAYER_H, 16, box height in pixels.
- START_X, 100, reset value of left.
- START_Y, 100, reset value of top.
- STEP, 4, maximum pixels moved per frame tick (1..15).
- SETTLE, 2, cycles to wait after a position change before sampling deny (1..7).
- X_MAX, 639, last valid screen column.
- Y_MAX, 479, last valid screen row.

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- frame_clk  input  1  frame tick, synchronous to Clk; rising edge starts a move
- dir  input  4  requested direction {up,down,left,right}; must be one-hot to move
- deny_up  input  1  moving up from the current box hits a wall
- deny_down  input  1  moving down is blocked
- deny_left  input  1  moving left is blocked
- deny_right  input  1  moving right is blocked
- top  output  10  box top row
- bottom  output  10  box bottom row (top+PLAYER_H-1)
- left  output  10  box left column
- right  output  10  box right column (left+PLAYER_W-1)
- busy  output  1  high while a move sequence is in progress
- blocked  output  1  one-cycle pulse when a move is cut short
- step_count  output  16  total pixels moved since reset, saturating at 0xFFFF

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - top=START_Y, left=START_X, bottom=START_Y+PLAYER_H-1, right=START_X+PLAYER_W-1.
  - busy=0, blocked=0, step_count=0, state=IDLE, frame_q=0.
  - Deasserting Reset_n mid-move abandons the move; the box is already at the start position.
- Edge detect: frame_q registers frame_clk every cycle. edge = frame_clk & ~frame_q.
- bottom and right are registered and always updated together with top and left, so the box never tears.
- IDLE:
  - On edge with dir one-hot: capture dir into dir_r, load rem=STEP and cnt=SETTLE, go to SETTLE.
  - On edge with dir zero or multi-hot: no action.
  - Without edge: stay in IDLE.
- SETTLE: cnt decrements each cycle; when cnt reaches 1, go to CHECK. The state lasts exactly SETTLE cycles.
- CHECK (1 cycle), blocked case:
  - Condition: the deny flag selected by dir_r is 1, or the box is at the screen edge (up: top==0; down: bottom==Y_MAX; left: left==0; right: right==X_MAX).
  - Action: blocked=1 for this cycle, no position change, go to IDLE.
- CHECK, otherwise:
  - On the clock edge leaving CHECK, the box moves 1 pixel in dir_r and step_count increments (saturating).
  - rem decrements. If the new rem is 0, go to IDLE; else reload cnt=SETTLE and go to SETTLE.
- busy = (state != IDLE).
- Frame edges that arrive while busy are ignored; no queuing.
- A full unblocked move takes STEP*(SETTLE+1) cycles after the edge cycle. Integration guarantees this is less than the frame period.
- dir changes while busy have no effect; dir_r is held for the whole sequence.
- Deny flags are sampled only in CHECK; glitches during SETTLE are ignored.
- Arithmetic is unsigned 10-bit. Bounds checks prevent wrap, so the box never leaves 0..X_MAX or 0..Y_MAX.

Test Plan:
- Defaults, reset -> top=100, bottom=115, left=100, right=115, busy=0, step_count=0.
- dir=4'b1000, all deny=0, one frame_clk rising edge -> busy high for 12 cycles; final top=96, bottom=111, left=100; step_count=4; no blocked pulse.
- dir=up; bench raises deny_up once top==98 -> box stops at top=98; blocked pulses exactly once; busy falls the following cycle; step_count=2.
- dir=4'b1010, frame edge -> no movement, busy stays 0, step_count unchanged; dir=4'b0000 gives the same result.
- START_X=2, dir=left (4'b0010), all deny=0 -> left goes 2→1→0 and then stops; blocked pulse; right=15.
- Second frame edge 3 cycles into a move -> ignored, total move 4 pixels. Then Reset_n pulsed low at cycle 5 of a new move -> outputs return immediately to the start box, busy=0, step_count=0.

Source files
------------

// File: rtl/maze_move_ctrl_if.sv
// maze_move_ctrl_if: bundle between the motion sequencer and its surroundings.
//   frame_clk / dir / deny_*     : frame tick, requested direction, wall flags
//   top/bottom/left/right        : player bounding box (registered, coherent)
//   busy / blocked / step_count  : sequencer status and running pixel count
// slave  : the sequencer side
// master : the driving side (game logic / testbench)
interface maze_move_ctrl_if;
  logic        frame_clk;
  logic [3:0]  dir;          // {up,down,left,right}
  logic        deny_up;
  logic        deny_down;
  logic        deny_left;
  logic        deny_right;
  logic [9:0]  top;
  logic [9:0]  bottom;
  logic [9:0]  left;
  logic [9:0]  right;
  logic        busy;
  logic        blocked;
  logic [15:0] step_count;

  modport slave (
    input  frame_clk, dir, deny_up, deny_down, deny_left, deny_right,
    output top, bottom, left, right, busy, blocked, step_count
  );

  modport master (
    output frame_clk, dir, deny_up, deny_down, deny_left, deny_right,
    input  top, bottom, left, right, busy, blocked, step_count
  );
endinterface

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: per-frame player-motion sequencer.
// A rising frame_clk with a one-hot dir starts a sequence of up to STEP
// single-pixel moves. Before each pixel the collision arrays get SETTLE
// cycles to react to the new box, then the matching deny flag and the
// screen edge are checked in a single CHECK cycle.
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   mv (slave)   : frame tick, dir, deny flags in; box, busy, blocked,
//                  step_count out
module maze_move_ctrl #(
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int START_X  = 100,
  parameter int START_Y  = 100,
  parameter int STEP     = 4,
  parameter int SETTLE   = 2,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479
) (
  input  logic Clk,
  input  logic Reset_n,
  maze_move_ctrl_if.slave mv
);

  localparam logic [9:0] TOP0   = 10'(START_Y);
  localparam logic [9:0] LEFT0  = 10'(START_X);
  localparam logic [9:0] BOT0   = 10'(START_Y + PLAYER_H - 1);
  localparam logic [9:0] RIGHT0 = 10'(START_X + PLAYER_W - 1);
  localparam logic [9:0] XM     = 10'(X_MAX);
  localparam logic [9:0] YM     = 10'(Y_MAX);
  localparam logic [3:0] STEP_L = 4'(STEP);
  localparam logic [2:0] SET_L  = 3'(SETTLE);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK} state_t;

  state_t      state, state_n;
  logic        frame_q;
  logic [3:0]  dir_r, dir_n;
  logic [3:0]  rem, rem_n;
  logic [2:0]  cnt, cnt_n;
  logic [9:0]  top_r, bot_r, left_r, right_r;
  logic [15:0] steps;
  logic        frame_edge, dir_onehot, stop, move, blk;

  assign frame_edge = mv.frame_clk & ~frame_q;
  assign dir_onehot = (mv.dir != 4'd0) && ((mv.dir & (mv.dir - 4'd1)) == 4'd0);

  // Wall or screen edge in the latched direction; dir_r is one-hot here.
  always_comb begin
    stop = 1'b0;
    case (dir_r)
      4'b1000: stop = mv.deny_up    | (top_r == 10'd0);
      4'b0100: stop = mv.deny_down  | (bot_r == YM);
      4'b0010: stop = mv.deny_left  | (left_r == 10'd0);
      default: stop = mv.deny_right | (right_r == XM);
    endcase
  end

  always_comb begin
    state_n = state;
    dir_n   = dir_r;
    rem_n   = rem;
    cnt_n   = cnt;
    move    = 1'b0;
    blk     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_edge && dir_onehot) begin
          dir_n   = mv.dir;
          rem_n   = STEP_L;
          cnt_n   = SET_L;
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == 3'd1) state_n = ST_CHECK;
        else             cnt_n   = cnt - 3'd1;
      end
      ST_CHECK: begin
        if (stop) begin
          blk     = 1'b1;
          state_n = ST_IDLE;
        end else begin
          move  = 1'b1;
          rem_n = rem - 4'd1;
          if (rem == 4'd1) begin
            state_n = ST_IDLE;
          end else begin
            cnt_n   = SET_L;
            state_n = ST_SETTLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      frame_q <= 1'b0;
      dir_r   <= 4'd0;
      rem     <= 4'd0;
      cnt     <= 3'd0;
    end else begin
      state   <= state_n;
      frame_q <= mv.frame_clk;
      dir_r   <= dir_n;
      rem     <= rem_n;
      cnt     <= cnt_n;
    end
  end

  // Opposite edges move with their partner so the box never tears.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      top_r   <= TOP0;
      bot_r   <= BOT0;
      left_r  <= LEFT0;
      right_r <= RIGHT0;
      steps   <= 16'd0;
    end else if (move) begin
      case (dir_r)
        4'b1000: begin top_r  <= top_r  - 10'd1; bot_r   <= bot_r   - 10'd1; end
        4'b0100: begin top_r  <= top_r  + 10'd1; bot_r   <= bot_r   + 10'd1; end
        4'b0010: begin left_r <= left_r - 10'd1; right_r <= right_r - 10'd1; end
        default: begin left_r <= left_r + 10'd1; right_r <= right_r + 10'd1; end
      endcase
      if (steps != 16'hFFFF) steps <= steps + 16'd1;
    end
  end

  assign mv.top        = top_r;
  assign mv.bottom     = bot_r;
  assign mv.left       = left_r;
  assign mv.right      = right_r;
  assign mv.busy       = (state != ST_IDLE);
  assign mv.blocked    = blk;
  assign mv.step_count = steps;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Bench for maze_move_ctrl: directed scenarios plus randomized moves checked
// against a position/budget model (pixels moved = min(STEP, room), zero if
// the wall flag is up).
module tb_maze_move_ctrl;
  localparam int W = 16, H = 16, STEP = 4, S = 2, XM = 639, YM = 479;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_checks = 0, n_errors = 0;

  maze_move_ctrl_if mif();
  maze_move_ctrl_if eif();

  maze_move_ctrl u_dut  (.Clk(Clk), .Reset_n(Reset_n), .mv(mif.slave));
  maze_move_ctrl #(.START_X(2)) u_edge (.Clk(Clk), .Reset_n(Reset_n), .mv(eif.slave));

  always #5 Clk = ~Clk;

  // Cycle-level activity counters, sampled just before each active edge.
  int busy_cyc = 0, blk_cnt = 0, e_busy_cyc = 0, e_blk_cnt = 0;
  always @(posedge Clk) begin
    if (mif.busy === 1'b1)    busy_cyc   <= busy_cyc + 1;
    if (mif.blocked === 1'b1) blk_cnt    <= blk_cnt + 1;
    if (eif.busy === 1'b1)    e_busy_cyc <= e_busy_cyc + 1;
    if (eif.blocked === 1'b1) e_blk_cnt  <= e_blk_cnt + 1;
  end

  task automatic do_reset();
    mif.frame_clk = 0; mif.dir = 0;
    mif.deny_up = 0; mif.deny_down = 0; mif.deny_left = 0; mif.deny_right = 0;
    eif.frame_clk = 0; eif.dir = 0;
    eif.deny_up = 0; eif.deny_down = 0; eif.deny_left = 0; eif.deny_right = 0;
    Reset_n = 0;
    #13;
    @(negedge Clk);
    Reset_n = 1;
    @(negedge Clk);
  endtask

  task automatic pulse(input bit e);
    @(negedge Clk);
    if (e) eif.frame_clk = 1; else mif.frame_clk = 1;
    @(negedge Clk);
    if (e) eif.frame_clk = 0; else mif.frame_clk = 0;
  endtask

  task automatic wait_idle(input bit e);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      if ((e ? eif.busy : mif.busy) == 1'b0) begin done = 1; break; end
      @(negedge Clk);
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL wait_idle: busy still %b after 300 cycles, required 0", e ? eif.busy : mif.busy);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({mif.top, mif.bottom, mif.left, mif.right} !== {10'd100, 10'd115, 10'd100, 10'd115}) begin
      n_errors++;
      $display("FAIL reset_box: got t=%0d b=%0d l=%0d r=%0d, required 100 115 100 115",
               mif.top, mif.bottom, mif.left, mif.right);
    end
    n_checks++;
    if ({mif.busy, mif.blocked, mif.step_count} !== {1'b0, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL reset_status: got busy=%b blocked=%b steps=%0d, required 0 0 0",
               mif.busy, mif.blocked, mif.step_count);
    end
    n_checks++;
    if ({eif.left, eif.right} !== {10'd2, 10'd17}) begin
      n_errors++;
      $display("FAIL reset_edge_box: got l=%0d r=%0d, required 2 17", eif.left, eif.right);
    end
  endtask

  task automatic test_move_up();
    int b0, k0;
    do_reset();
    b0 = busy_cyc; k0 = blk_cnt;
    mif.dir = 4'b1000;
    pulse(0);
    wait_idle(0);
    n_checks++;
    if (busy_cyc - b0 !== 12) begin
      n_errors++;
      $display("FAIL up_busy_len: got %0d cycles, required 12", busy_cyc - b0);
    end
    n_checks++;
    if ({mif.top, mif.bottom, mif.left, mif.right, mif.step_count} !==
        {10'd96, 10'd111, 10'd100, 10'd115, 16'd4}) begin
      n_errors++;
      $display("FAIL up_box: got t=%0d b=%0d l=%0d r=%0d steps=%0d, required 96 111 100 115 4",
               mif.top, mif.bottom, mif.left, mif.right, mif.step_count);
    end
    n_checks++;
    if (blk_cnt - k0 !== 0) begin
      n_errors++;
      $display("FAIL up_no_block: got %0d blocked pulses, required 0", blk_cnt - k0);
    end
  endtask

  task automatic test_deny_up();
    int k0, blk_i = -10, idle_i = -1;
    do_reset();
    k0 = blk_cnt;
    mif.dir = 4'b1000;
    pulse(0);
    for (int i = 0; i < 100; i++) begin
      if (mif.top == 10'd98) mif.deny_up = 1;
      if (mif.blocked) blk_i = i;
      if (!mif.busy) begin idle_i = i; break; end
      @(negedge Clk);
    end
    n_checks++;
    if ({mif.top, mif.bottom, mif.step_count} !== {10'd98, 10'd113, 16'd2}) begin
      n_errors++;
      $display("FAIL deny_box: got t=%0d b=%0d steps=%0d, required 98 113 2",
               mif.top, mif.bottom, mif.step_count);
    end
    n_checks++;
    if (blk_cnt - k0 !== 1) begin
      n_errors++;
      $display("FAIL deny_pulses: got %0d blocked pulses, required 1", blk_cnt - k0);
    end
    n_checks++;
    if (idle_i !== blk_i + 1) begin
      n_errors++;
      $display("FAIL deny_busy_fall: busy fell %0d cycles after blocked, required 1", idle_i - blk_i);
    end
    mif.deny_up = 0;
  endtask

  task automatic test_bad_dir();
    logic [3:0] dirs [3];
    dirs[0] = 4'b1010; dirs[1] = 4'b0000; dirs[2] = 4'b1111;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      int b0 = busy_cyc;
      mif.dir = dirs[i];
      pulse(0);
      repeat (6) @(negedge Clk);
      n_checks++;
      if ({busy_cyc - b0, 32'(mif.top), 32'(mif.left), 32'(mif.step_count)} !==
          {32'd0, 32'd100, 32'd100, 32'd0}) begin
        n_errors++;
        $display("FAIL bad_dir_%b: got busy_cyc=%0d t=%0d l=%0d steps=%0d, required 0 100 100 0",
                 dirs[i], busy_cyc - b0, mif.top, mif.left, mif.step_count);
      end
    end
  endtask

  task automatic test_edge_left();
    int b0, k0, changes = 0;
    bit bad = 0;
    logic [9:0] prev;
    do_reset();
    b0 = e_busy_cyc; k0 = e_blk_cnt;
    prev = eif.left;
    eif.dir = 4'b0010;
    pulse(1);
    for (int i = 0; i < 100; i++) begin
      if (eif.left != prev) begin
        if (eif.left != prev - 10'd1) bad = 1;
        changes++;
        prev = eif.left;
      end
      if (!eif.busy) break;
      @(negedge Clk);
    end
    n_checks++;
    if ({eif.left, eif.right, eif.step_count} !== {10'd0, 10'd15, 16'd2}) begin
      n_errors++;
      $display("FAIL edge_box: got l=%0d r=%0d steps=%0d, required 0 15 2",
               eif.left, eif.right, eif.step_count);
    end
    n_checks++;
    if (changes !== 2 || bad) begin
      n_errors++;
      $display("FAIL edge_path: got %0d changes bad=%0d, required 2 unit steps", changes, bad);
    end
    n_checks++;
    if (e_blk_cnt - k0 !== 1 || e_busy_cyc - b0 !== 3 * (S + 1)) begin
      n_errors++;
      $display("FAIL edge_status: got blocked=%0d busy_cyc=%0d, required 1 %0d",
               e_blk_cnt - k0, e_busy_cyc - b0, 3 * (S + 1));
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    do_reset();
    b0 = busy_cyc;
    mif.dir = 4'b1000;
    pulse(0);
    @(negedge Clk);
    pulse(0);            // lands mid-sequence, must be ignored
    wait_idle(0);
    n_checks++;
    if ({mif.top, mif.step_count} !== {10'd96, 16'd4} || busy_cyc - b0 !== 12) begin
      n_errors++;
      $display("FAIL b2b_ignore: got t=%0d steps=%0d busy_cyc=%0d, required 96 4 12",
               mif.top, mif.step_count, busy_cyc - b0);
    end
    mif.dir = 4'b0100;
    pulse(0);
    repeat (4) @(negedge Clk);
    #2 Reset_n = 0;
    #1;
    n_checks++;
    if ({mif.top, mif.bottom, mif.left, mif.right, mif.busy, mif.step_count} !==
        {10'd100, 10'd115, 10'd100, 10'd115, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL midmove_reset: got t=%0d b=%0d l=%0d r=%0d busy=%b steps=%0d, required 100 115 100 115 0 0",
               mif.top, mif.bottom, mif.left, mif.right, mif.busy, mif.step_count);
    end
    @(negedge Clk);
    Reset_n = 1;
    @(negedge Clk);
  endtask

  task automatic test_random();
    int m_top = 100, m_left = 100, m_steps = 0;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      logic [3:0] d;
      bit du, dd, dl, dr, deny;
      int room, moved, exp_busy, exp_blk, b0, k0;
      if ($urandom_range(0, 3) < 3) d = 4'(1 << $urandom_range(0, 3));
      else                          d = 4'($urandom_range(0, 15));
      du = ($urandom_range(0, 5) == 0); dd = ($urandom_range(0, 5) == 0);
      dl = ($urandom_range(0, 5) == 0); dr = ($urandom_range(0, 5) == 0);
      mif.dir = d;
      mif.deny_up = du; mif.deny_down = dd; mif.deny_left = dl; mif.deny_right = dr;
      b0 = busy_cyc; k0 = blk_cnt;
      pulse(0);
      wait_idle(0);
      // model
      if ($countones(d) != 1) begin
        moved = 0; exp_busy = 0; exp_blk = 0;
      end else begin
        case (d)
          4'b1000: begin room = m_top;               deny = du; end
          4'b0100: begin room = YM - (m_top + H - 1); deny = dd; end
          4'b0010: begin room = m_left;              deny = dl; end
          default: begin room = XM - (m_left + W - 1); deny = dr; end
        endcase
        moved = deny ? 0 : (room < STEP ? room : STEP);
        exp_blk  = (moved < STEP) ? 1 : 0;
        exp_busy = (moved == STEP) ? STEP * (S + 1) : (moved + 1) * (S + 1);
        case (d)
          4'b1000: m_top  -= moved;
          4'b0100: m_top  += moved;
          4'b0010: m_left -= moved;
          default: m_left += moved;
        endcase
        m_steps += moved;
      end
      n_checks++;
      if (mif.top !== 10'(m_top) || mif.bottom !== 10'(m_top + H - 1) ||
          mif.left !== 10'(m_left) || mif.right !== 10'(m_left + W - 1)) begin
        n_errors++;
        $display("FAIL rand_box[%0d] dir=%b: got t=%0d b=%0d l=%0d r=%0d, required %0d %0d %0d %0d",
                 it, d, mif.top, mif.bottom, mif.left, mif.right,
                 m_top, m_top + H - 1, m_left, m_left + W - 1);
      end
      n_checks++;
      if (32'(mif.step_count) !== m_steps || busy_cyc - b0 !== exp_busy || blk_cnt - k0 !== exp_blk) begin
        n_errors++;
        $display("FAIL rand_status[%0d] dir=%b: got steps=%0d busy=%0d blk=%0d, required %0d %0d %0d",
                 it, d, mif.step_count, busy_cyc - b0, blk_cnt - k0, m_steps, exp_busy, exp_blk);
      end
    end
    mif.deny_up = 0; mif.deny_down = 0; mif.deny_left = 0; mif.deny_right = 0;
  endtask

  initial begin
    test_reset();
    test_move_up();
    test_deny_up();
    test_bad_dir();
    test_edge_left();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at 2ms, required completion");
    $fatal(1);
  end
endmodule
